tribus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 8-bit tri-state bus built from `tribuf` drivers. It owns the `c` enable of every driver on the bus and guarantees at most one enable is high in any cycle. It inserts idle turnaround cycles between owners so no two drivers overlap, and it can optionally bound how long one owner holds the bus.

---
 rtl/tribus_pkg.sv | 20 ++
 rtl/tribus_arbiter_rr_pick.sv | 44 ++++
 rtl/tribus_arbiter.sv | 127 ++++++++++++
 tb/tb_tribus_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tribus_pkg.sv
// Shared types and defaults for the tri-state bus arbiter.
// The optional hold timeout is enabled with the TRIBUS_TIMEOUT_EN macro.
package tribus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam int DEF_N           = 4;
   localparam int DEF_TURN_CYCLES = 1;
   localparam int DEF_MAX_HOLD    = 16;

   // Width of an index into N requesters, never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping modulo N.
// Used by tribus_arbiter in both builds (TRIBUS_TIMEOUT_EN defined or not).
module rr_pick
   import tribus_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic [N-1:0]              req,
   input  logic [idx_width(N)-1:0]   ptr,
   output logic [N-1:0]              pick,
   output logic [idx_width(N)-1:0]   pick_idx,
   output logic                      any
);

   localparam int W = idx_width(N);

   logic [N-1:0] rot;
   logic [N-1:0] scan;
   int           first;
   int           sum;

   // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
   always_comb begin
      rot   = N'({req, req} >> ptr);
      scan  = rot;
      any   = 1'b0;
      first = 0;
      for (int k = 0; k < N; k++) begin
         if (!any && scan[0]) begin
            any   = 1'b1;
            first = k;
         end
         scan = scan >> 1;
      end
      sum = int'(ptr) + first;
      if (sum >= N) sum = sum - N;
      pick_idx = W'(sum);
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign pick[gi] = any && (pick_idx == W'(gi));
   end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus with idle turnaround between owners.
// Define TRIBUS_TIMEOUT_EN to bound each ownership to MAX_HOLD grant cycles (tmo pulses on force-end).
module tribus_arbiter
   import tribus_pkg::*;
#(
   parameter int N           = DEF_N,
   parameter int TURN_CYCLES = DEF_TURN_CYCLES,
   parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N-1:0]             req,
   output logic [N-1:0]             gnt,
   output logic [N-1:0]             en,
   output logic [idx_width(N)-1:0]  owner,
   output logic                     busy,
   output logic                     tmo
);

   localparam int W = idx_width(N);

   if (N < 2 || N > 8 || TURN_CYCLES < 1 || TURN_CYCLES > 4 || MAX_HOLD < 1) begin : g_bad_cfg
      $error("tribus_arbiter: parameter out of range");
   end

   state_t         state_reg;
   logic [N-1:0]   gnt_reg;
   logic [W-1:0]   owner_reg;
   logic [W-1:0]   ptr_reg;
   logic           busy_reg;
   logic           tmo_reg;
   logic [2:0]     turn_cnt_reg;

   logic [N-1:0]   pick;
   logic [W-1:0]   pick_idx;
   logic [W-1:0]   next_ptr;
   logic           any;
   logic           owner_req;
   logic           turn_done;
   logic           force_end;

   rr_pick #(.N(N)) u_pick (
      .req      (req),
      .ptr      (ptr_reg),
      .pick     (pick),
      .pick_idx (pick_idx),
      .any      (any)
   );

   assign next_ptr  = (pick_idx == W'(N - 1)) ? '0 : pick_idx + 1'b1;
   // gnt_reg is one-hot on the owner while in GRANT, so this is req[owner].
   assign owner_req = |(req & gnt_reg);
   assign turn_done = (turn_cnt_reg == 3'(TURN_CYCLES - 1));

`ifdef TRIBUS_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hold_reg;

   // Zero outside GRANT, so it is already clear on every entry to GRANT.
   always_ff @(posedge clk) begin
      if (rst || state_reg != GRANT) hold_reg <= '0;
      else                           hold_reg <= hold_reg + 1'b1;
   end

   assign force_end = (state_reg == GRANT) && (hold_reg == HW'(MAX_HOLD - 1));
`else
   assign force_end = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         gnt_reg      <= '0;
         owner_reg    <= '0;
         ptr_reg      <= '0;
         busy_reg     <= 1'b0;
         tmo_reg      <= 1'b0;
         turn_cnt_reg <= '0;
      end else begin
         tmo_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (any) begin
                  state_reg <= GRANT;
                  gnt_reg   <= pick;
                  owner_reg <= pick_idx;
                  ptr_reg   <= next_ptr;
                  busy_reg  <= 1'b1;
               end
            end
            GRANT: begin
               if (!owner_req || force_end) begin
                  state_reg    <= TURN;
                  gnt_reg      <= '0;
                  turn_cnt_reg <= '0;
                  tmo_reg      <= owner_req;
               end
            end
            TURN: begin
               if (!turn_done) begin
                  turn_cnt_reg <= turn_cnt_reg + 1'b1;
               end else if (any) begin
                  state_reg <= GRANT;
                  gnt_reg   <= pick;
                  owner_reg <= pick_idx;
                  ptr_reg   <= next_ptr;
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               gnt_reg   <= '0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt   = gnt_reg;
   assign en    = gnt_reg;
   assign owner = owner_reg;
   assign busy  = busy_reg;
   assign tmo   = tmo_reg;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Bench for tribus_arbiter: hand vectors, corner sequences and randomized req against a behavioural model.
// Timeout expectations follow whether TRIBUS_TIMEOUT_EN is defined for the build.
module tb_tribus_arbiter;
   import tribus_pkg::*;

   localparam int N  = 4;
   localparam int TC = 1;
   localparam int MH = 4;
   localparam int W  = idx_width(N);
`ifdef TRIBUS_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic [N-1:0]  en;
   logic [W-1:0]  owner;
   logic          busy;
   logic          tmo;

   always #5 clk = ~clk;

   tribus_arbiter #(.N(N), .TURN_CYCLES(TC), .MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .gnt   (gnt),
      .en    (en),
      .owner (owner),
      .busy  (busy),
      .tmo   (tmo)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] en;
      int           owner;
      bit           busy;
   } vec_t;

   // Behavioural model: who holds the bus, how long, and how much turnaround is left.
   int           m_owner;
   int           m_last;
   int           m_gap;
   int           m_held;
   int           m_ptr;
   bit           m_tmo;

   function automatic bit bit_of(input logic [N-1:0] v, input int i);
      logic [N-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 0;
      m_gap   = 0;
      m_held  = 0;
      m_ptr   = 0;
      m_tmo   = 1'b0;
   endtask

   task automatic model_arb(input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (m_owner < 0 && bit_of(r, i)) begin
            m_owner = i;
            m_last  = i;
            m_held  = 1;
         end
      end
      if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
   endtask

   task automatic model_step(input logic [N-1:0] r);
      bit dropped;
      bit forced;
      m_tmo = 1'b0;
      if (m_owner >= 0) begin
         dropped = !bit_of(r, m_owner);
         forced  = TMO_EN && (m_held >= MH);
         if (dropped || forced) begin
            m_tmo   = !dropped;
            m_owner = -1;
            m_gap   = TC;
         end else begin
            m_held++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) model_arb(r);
      end else begin
         model_arb(r);
      end
   endtask

   task automatic check(input string name, input logic [N-1:0] x_en, input int x_owner,
                        input bit x_busy, input bit x_tmo, input bit verbose);
      checks++;
      if ({en, gnt, owner, busy, tmo} !== {x_en, x_en, W'(x_owner), x_busy, x_tmo}) begin
         failures++;
         $display("FAIL %s: got en=%b gnt=%b owner=%0d busy=%b tmo=%b, expected en=%b owner=%0d busy=%b tmo=%b",
                  name, en, gnt, owner, busy, tmo, x_en, x_owner, x_busy, x_tmo);
      end else if (verbose) begin
         $display("ok   %s: req=%b en=%b owner=%0d busy=%b tmo=%b", name, req, en, owner, busy, tmo);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      check("reset", '0, 0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
   endtask

   vec_t tbl[29];

   initial begin
      logic [N-1:0] x_en;
      logic [N-1:0] mask;

      tbl = '{
         // single grant, handoff with one turnaround cycle, no preemption
         '{4'b0001, 4'b0001, 0, 1'b1}, '{4'b0011, 4'b0001, 0, 1'b1},
         '{4'b0010, 4'b0000, 0, 1'b1}, '{4'b0010, 4'b0010, 1, 1'b1},
         '{4'b0011, 4'b0010, 1, 1'b1}, '{4'b0011, 4'b0010, 1, 1'b1},
         '{4'b0001, 4'b0000, 1, 1'b1}, '{4'b0001, 4'b0001, 0, 1'b1},
         '{4'b0000, 4'b0000, 0, 1'b1}, '{4'b0000, 4'b0000, 0, 1'b0},
         '{4'b0000, 4'b0000, 0, 1'b0},
         // round-robin between 0 and 3, each holding 3 cycles, pointer wraps 3 -> 0
         '{4'b1001, 4'b1000, 3, 1'b1}, '{4'b1001, 4'b1000, 3, 1'b1},
         '{4'b1001, 4'b1000, 3, 1'b1}, '{4'b0001, 4'b0000, 3, 1'b1},
         '{4'b1001, 4'b0001, 0, 1'b1}, '{4'b1001, 4'b0001, 0, 1'b1},
         '{4'b1001, 4'b0001, 0, 1'b1}, '{4'b1000, 4'b0000, 0, 1'b1},
         '{4'b1001, 4'b1000, 3, 1'b1}, '{4'b1001, 4'b1000, 3, 1'b1},
         '{4'b1001, 4'b1000, 3, 1'b1}, '{4'b0001, 4'b0000, 3, 1'b1},
         '{4'b1001, 4'b0001, 0, 1'b1}, '{4'b0000, 4'b0000, 0, 1'b1},
         '{4'b0000, 4'b0000, 0, 1'b0},
         // request dropped the cycle it is granted still owns the bus one cycle
         '{4'b0100, 4'b0100, 2, 1'b1}, '{4'b0000, 4'b0000, 2, 1'b1},
         '{4'b0000, 4'b0000, 2, 1'b0}
      };

      do_reset();
      for (int i = 0; i < 29; i++) begin
         req = tbl[i].req;
         tick();
         check($sformatf("vec%0d", i), tbl[i].en, tbl[i].owner, tbl[i].busy, 1'b0, 1'b1);
      end

      // Owner 0 keeps requesting while 2 waits.
      do_reset();
      req = 4'b0101;
      for (int c = 1; c <= 6; c++) begin
         tick();
`ifdef TRIBUS_TIMEOUT_EN
         if (c <= 4)      check($sformatf("hold%0d", c), 4'b0001, 0, 1'b1, 1'b0, 1'b1);
         else if (c == 5) check($sformatf("hold%0d", c), 4'b0000, 0, 1'b1, 1'b1, 1'b1);
         else             check($sformatf("hold%0d", c), 4'b0100, 2, 1'b1, 1'b0, 1'b1);
`else
         check($sformatf("hold%0d", c), 4'b0001, 0, 1'b1, 1'b0, 1'b1);
`endif
      end

      // Reset in the middle of a grant, then the pointer must be back at 0.
      do_reset();
      req = 4'b0010;
      tick();
      check("mid_grant", 4'b0010, 1, 1'b1, 1'b0, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      check("mid_reset", 4'b0000, 0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      req = 4'b0011;
      tick();
      check("ptr_after_reset", 4'b0001, 0, 1'b1, 1'b0, 1'b1);

      // Randomized sticky requests with occasional resets.
      do_reset();
      model_reset();
      for (int c = 0; c < 1000; c++) begin
         mask = '0;
         for (int b = 0; b < N; b++) mask = {mask[N-2:0], ($urandom_range(0, 4) == 0)};
         req = req ^ mask;
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
            model_reset();
         end else begin
            rst = 1'b0;
            model_step(req);
         end
         tick();
         x_en = '0;
         if (m_owner >= 0) x_en = N'(1) << m_owner;
         check($sformatf("rand%0d", c), x_en, m_last, (m_owner >= 0) || (m_gap > 0), m_tmo, 1'b0);
         checks++;
         if ($countones(en) > 1) begin
            failures++;
            $display("FAIL onehot%0d: en=%b has more than one enable high, at most one allowed", c, en);
         end
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
